// File: rtl/rv_retire_trace_buffer.sv
// rv_retire_trace_buffer: filtered, canonicalised retire-trace FIFO with show-ahead valid/ready drain.
// Optional back-pressure output enabled by defining RV_RETIRE_TRACE_STALL_EN.
module rv_retire_trace_buffer #(
   parameter int XLEN   = 32,
   parameter int DEPTH  = 8,
   parameter int WARMUP = 3,
   parameter int CNT_W  = 32
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic                     clear_i,
   input  logic                     ret_valid_i,
   input  logic [XLEN-1:0]          ret_pc_i,
   input  logic [31:0]              ret_instr_i,
   input  logic [4:0]               ret_rd_i,
   input  logic [XLEN-1:0]          ret_rd_data_i,
   input  logic                     ret_mem_we_i,
   input  logic [XLEN-1:0]          ret_mem_addr_i,
   input  logic [XLEN-1:0]          ret_mem_data_i,
   output logic                     tr_valid_o,
   input  logic                     tr_ready_i,
   output logic [XLEN-1:0]          tr_pc_o,
   output logic [31:0]              tr_instr_o,
   output logic [4:0]               tr_rd_o,
   output logic [XLEN-1:0]          tr_rd_data_o,
   output logic                     tr_mem_we_o,
   output logic [XLEN-1:0]          tr_mem_addr_o,
   output logic [XLEN-1:0]          tr_mem_data_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     overflow_o,
   output logic [CNT_W-1:0]         drop_cnt_o,
   output logic [CNT_W-1:0]         instret_o,
   output logic                     stall_req_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
      logic [4:0]      rd;
      logic [XLEN-1:0] rd_data;
      logic            mem_we;
      logic [XLEN-1:0] mem_addr;
      logic [XLEN-1:0] mem_data;
   } rec_t;
   rec_t            r_mem [DEPTH];
   rec_t            w_rec, w_head;
   logic [AW-1:0]   r_wr, r_rd;
   logic [LW-1:0]   r_level;
   logic [31:0]     r_warm;
   logic [CNT_W-1:0] r_drop, r_instret;
   logic            r_ovf;
   logic            w_is_bs, w_q, w_full, w_pop, w_push, w_drop;
   always_comb begin
      w_is_bs        = (ret_instr_i[6:0] == 7'b1100011) || (ret_instr_i[6:0] == 7'b0100011);
      w_rec.pc       = ret_pc_i;
      w_rec.instr    = ret_instr_i;
      w_rec.rd       = w_is_bs ? 5'd0 : ret_rd_i;
      w_rec.rd_data  = (w_is_bs || ret_rd_i == 5'd0) ? '0 : ret_rd_data_i;
      w_rec.mem_we   = ret_mem_we_i;
      w_rec.mem_addr = ret_mem_we_i ? ret_mem_addr_i : '0;
      w_rec.mem_data = ret_mem_we_i ? ret_mem_data_i : '0;
      w_q            = ret_valid_i && (r_warm == 32'd0) && (ret_instr_i != 32'h0) && !clear_i;
      w_full         = r_level == LW'(DEPTH);
      w_pop          = (r_level != '0) && tr_ready_i && !clear_i;
      w_push         = w_q && (!w_full || w_pop);
      w_drop         = w_q && w_full && !w_pop;
   end
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr      <= '0;
         r_rd      <= '0;
         r_level   <= '0;
         r_ovf     <= 1'b0;
         r_drop    <= '0;
         r_instret <= '0;
         r_warm    <= 32'(WARMUP);
      end else begin
         if (r_warm != 32'd0) r_warm <= r_warm - 32'd1;
         r_instret <= r_instret + CNT_W'(w_q);
         if (clear_i) begin
            r_level <= '0;
            r_rd    <= r_wr;
            r_ovf   <= 1'b0;
         end else begin
            if (w_push) begin
               r_mem[r_wr] <= w_rec;
               r_wr        <= r_wr + AW'(1);
            end
            if (w_pop) r_rd <= r_rd + AW'(1);
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
            if (w_drop) begin
               r_ovf  <= 1'b1;
               r_drop <= r_drop + CNT_W'(1);
            end
         end
      end
   end
   assign w_head        = r_mem[r_rd];
   assign tr_valid_o    = r_level != '0;
   assign tr_pc_o       = w_head.pc;
   assign tr_instr_o    = w_head.instr;
   assign tr_rd_o       = w_head.rd;
   assign tr_rd_data_o  = w_head.rd_data;
   assign tr_mem_we_o   = w_head.mem_we;
   assign tr_mem_addr_o = w_head.mem_addr;
   assign tr_mem_data_o = w_head.mem_data;
   assign level_o       = r_level;
   assign overflow_o    = r_ovf;
   assign drop_cnt_o    = r_drop;
   assign instret_o     = r_instret;
`ifdef RV_RETIRE_TRACE_STALL_EN
   assign stall_req_o   = r_level >= LW'(DEPTH - 2);
`else
   assign stall_req_o   = 1'b0;
`endif
endmodule

// File: tb/tb_rv_retire_trace_buffer.sv
// tb_rv_retire_trace_buffer: directed scenario bench for rv_retire_trace_buffer (DEPTH=8, WARMUP=3).
module tb_rv_retire_trace_buffer;
`ifdef RV_RETIRE_TRACE_STALL_EN
   localparam bit STALL_EN = 1'b1;
`else
   localparam bit STALL_EN = 1'b0;
`endif
   logic        clk = 1'b0, rstn_i, clear_i, ret_valid_i, ret_mem_we_i, tr_ready_i;
   logic [31:0] ret_pc_i, ret_instr_i, ret_rd_data_i, ret_mem_addr_i, ret_mem_data_i;
   logic [4:0]  ret_rd_i, tr_rd_o;
   logic        tr_valid_o, tr_mem_we_o, overflow_o, stall_req_o;
   logic [31:0] tr_pc_o, tr_instr_o, tr_rd_data_o, tr_mem_addr_o, tr_mem_data_o;
   logic [3:0]  level_o;
   logic [31:0] drop_cnt_o, instret_o;
   int n_tests = 0, n_fail = 0;

   rv_retire_trace_buffer dut (
      .clk_i(clk), .rstn_i(rstn_i), .clear_i(clear_i), .ret_valid_i(ret_valid_i),
      .ret_pc_i(ret_pc_i), .ret_instr_i(ret_instr_i), .ret_rd_i(ret_rd_i),
      .ret_rd_data_i(ret_rd_data_i), .ret_mem_we_i(ret_mem_we_i),
      .ret_mem_addr_i(ret_mem_addr_i), .ret_mem_data_i(ret_mem_data_i),
      .tr_valid_o(tr_valid_o), .tr_ready_i(tr_ready_i), .tr_pc_o(tr_pc_o),
      .tr_instr_o(tr_instr_o), .tr_rd_o(tr_rd_o), .tr_rd_data_o(tr_rd_data_o),
      .tr_mem_we_o(tr_mem_we_o), .tr_mem_addr_o(tr_mem_addr_o), .tr_mem_data_o(tr_mem_data_o),
      .level_o(level_o), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o),
      .instret_o(instret_o), .stall_req_o(stall_req_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rec(input logic [31:0] pc, input logic [31:0] instr, input logic [4:0] rd,
                          input logic [31:0] rdd, input logic we, input logic [31:0] addr,
                          input logic [31:0] data);
      ret_valid_i = 1'b1; ret_pc_i = pc; ret_instr_i = instr; ret_rd_i = rd;
      ret_rd_data_i = rdd; ret_mem_we_i = we; ret_mem_addr_i = addr; ret_mem_data_i = data;
   endtask

   task automatic do_reset();
      ret_valid_i = 1'b0; clear_i = 1'b0; tr_ready_i = 1'b0;
      rstn_i = 1'b0;
      tick();
      rstn_i = 1'b1;
      repeat (3) tick();
   endtask

   task automatic test_reset();
      clear_i = 1'b0; tr_ready_i = 1'b0;
      set_rec(32'h0, 32'h00000013, 5'd1, 32'h1, 1'b0, 32'h0, 32'h0);
      rstn_i = 1'b0;
      #1;
      n_tests++; if (tr_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %0b exp 0", tr_valid_o); end
      n_tests++; if (level_o !== 4'd0) begin n_fail++; $display("FAIL rst_level got %0d exp 0", level_o); end
      n_tests++; if (instret_o !== 32'd0 || drop_cnt_o !== 32'd0 || overflow_o !== 1'b0) begin n_fail++; $display("FAIL rst_cnt got instret=%0d drop=%0d ovf=%0b exp 0 0 0", instret_o, drop_cnt_o, overflow_o); end
      n_tests++; if (tr_pc_o !== 32'd0 || tr_instr_o !== 32'd0 || stall_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_fields got pc=%h instr=%h stall=%0b exp 0", tr_pc_o, tr_instr_o, stall_req_o); end
      tick();
      rstn_i = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         ret_pc_i = 32'(4 * k);
         tick();
         n_tests++; if (level_o !== 4'd0) begin n_fail++; $display("FAIL warmup_c%0d level got %0d exp 0", k, level_o); end
      end
      ret_pc_i = 32'h10;
      tick();
      n_tests++; if (level_o !== 4'd1 || tr_valid_o !== 1'b1) begin n_fail++; $display("FAIL warmup_first level got %0d valid %0b exp 1 1", level_o, tr_valid_o); end
      n_tests++; if (tr_pc_o !== 32'h10) begin n_fail++; $display("FAIL warmup_pc got %h exp 00000010", tr_pc_o); end
      n_tests++; if (instret_o !== 32'd1) begin n_fail++; $display("FAIL warmup_instret got %0d exp 1", instret_o); end
      tick();
      n_tests++; if (level_o !== 4'd2) begin n_fail++; $display("FAIL midrst_pre level got %0d exp 2", level_o); end
      rstn_i = 1'b0;
      #1;
      n_tests++; if (level_o !== 4'd0 || tr_valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst level got %0d valid %0b exp 0 0", level_o, tr_valid_o); end
      ret_valid_i = 1'b0;
   endtask

   task automatic test_bubble();
      do_reset();
      tr_ready_i = 1'b1;
      set_rec(32'h0, 32'h00000013, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
      tick();
      n_tests++; if (level_o !== 4'd1 || tr_instr_o !== 32'h00000013 || tr_pc_o !== 32'h0) begin n_fail++; $display("FAIL bub_r0 got lvl=%0d instr=%h pc=%h exp 1 00000013 0", level_o, tr_instr_o, tr_pc_o); end
      set_rec(32'h4, 32'h00000000, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
      tick();
      n_tests++; if (level_o !== 4'd0 || tr_valid_o !== 1'b0) begin n_fail++; $display("FAIL bub_skip got lvl=%0d valid=%0b exp 0 0", level_o, tr_valid_o); end
      set_rec(32'h8, 32'h00a00093, 5'd1, 32'd10, 1'b0, 32'h0, 32'h0);
      tick();
      n_tests++; if (level_o !== 4'd1 || tr_instr_o !== 32'h00a00093 || tr_pc_o !== 32'h8) begin n_fail++; $display("FAIL bub_r1 got lvl=%0d instr=%h pc=%h exp 1 00a00093 8", level_o, tr_instr_o, tr_pc_o); end
      n_tests++; if (tr_rd_o !== 5'd1 || tr_rd_data_o !== 32'd10) begin n_fail++; $display("FAIL bub_rd got rd=%0d data=%0d exp 1 10", tr_rd_o, tr_rd_data_o); end
      ret_valid_i = 1'b0;
      tick();
      n_tests++; if (level_o !== 4'd0 || instret_o !== 32'd2) begin n_fail++; $display("FAIL bub_end got lvl=%0d instret=%0d exp 0 2", level_o, instret_o); end
   endtask

   task automatic test_canon();
      do_reset();
      set_rec(32'h20, 32'h00208463, 5'd8, 32'h55, 1'b0, 32'h77, 32'h99);
      tick();
      n_tests++; if (tr_rd_o !== 5'd0 || tr_rd_data_o !== 32'd0) begin n_fail++; $display("FAIL br_rd got rd=%0d data=%h exp 0 0", tr_rd_o, tr_rd_data_o); end
      n_tests++; if (tr_mem_we_o !== 1'b0 || tr_mem_addr_o !== 32'd0 || tr_mem_data_o !== 32'd0) begin n_fail++; $display("FAIL br_mem got we=%0b addr=%h data=%h exp 0 0 0", tr_mem_we_o, tr_mem_addr_o, tr_mem_data_o); end
      tr_ready_i = 1'b1;
      set_rec(32'h24, 32'h00112023, 5'd5, 32'h33, 1'b1, 32'h100, 32'hAB);
      tick();
      n_tests++; if (tr_pc_o !== 32'h24 || tr_rd_o !== 5'd0 || tr_rd_data_o !== 32'd0) begin n_fail++; $display("FAIL st_rd got pc=%h rd=%0d data=%h exp 24 0 0", tr_pc_o, tr_rd_o, tr_rd_data_o); end
      n_tests++; if (tr_mem_we_o !== 1'b1 || tr_mem_addr_o !== 32'h100 || tr_mem_data_o !== 32'hAB) begin n_fail++; $display("FAIL st_mem got we=%0b addr=%h data=%h exp 1 100 ab", tr_mem_we_o, tr_mem_addr_o, tr_mem_data_o); end
      set_rec(32'h28, 32'h00500013, 5'd0, 32'h5, 1'b0, 32'h0, 32'h0);
      tick();
      n_tests++; if (tr_pc_o !== 32'h28 || tr_rd_data_o !== 32'd0 || level_o !== 4'd1) begin n_fail++; $display("FAIL x0_data got pc=%h data=%h lvl=%0d exp 28 0 1", tr_pc_o, tr_rd_data_o, level_o); end
      ret_valid_i = 1'b0;
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         set_rec(32'(32'h1000 + 4 * i), 32'h00000013, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
         tick();
         if (i == 7) begin
            n_tests++; if (level_o !== 4'd8 || overflow_o !== 1'b0) begin n_fail++; $display("FAIL ovf_full got lvl=%0d ovf=%0b exp 8 0", level_o, overflow_o); end
         end
      end
      ret_valid_i = 1'b0;
      n_tests++; if (level_o !== 4'd8 || overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got lvl=%0d ovf=%0b exp 8 1", level_o, overflow_o); end
      n_tests++; if (drop_cnt_o !== 32'd2 || instret_o !== 32'd10) begin n_fail++; $display("FAIL ovf_cnt got drop=%0d instret=%0d exp 2 10", drop_cnt_o, instret_o); end
      tr_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         n_tests++; if (tr_valid_o !== 1'b1 || tr_pc_o !== 32'(32'h1000 + 4 * i)) begin n_fail++; $display("FAIL drain%0d got valid=%0b pc=%h exp 1 %h", i, tr_valid_o, tr_pc_o, 32'(32'h1000 + 4 * i)); end
         tick();
      end
      n_tests++; if (level_o !== 4'd0 || tr_valid_o !== 1'b0) begin n_fail++; $display("FAIL drain_end got lvl=%0d valid=%0b exp 0 0", level_o, tr_valid_o); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 9; i++) begin
         set_rec(32'(32'h1000 + 4 * i), 32'h00000013, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
         tick();
      end
      n_tests++; if (level_o !== 4'd8 || drop_cnt_o !== 32'd1 || overflow_o !== 1'b1) begin n_fail++; $display("FAIL b2b_fill got lvl=%0d drop=%0d ovf=%0b exp 8 1 1", level_o, drop_cnt_o, overflow_o); end
      tr_ready_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         n_tests++; if (tr_pc_o !== 32'(32'h1000 + 4 * i)) begin n_fail++; $display("FAIL b2b_head%0d got %h exp %h", i, tr_pc_o, 32'(32'h1000 + 4 * i)); end
         set_rec(32'(32'h2000 + 4 * i), 32'h00000013, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
         tick();
         n_tests++; if (level_o !== 4'd8 || drop_cnt_o !== 32'd1) begin n_fail++; $display("FAIL b2b_lvl%0d got lvl=%0d drop=%0d exp 8 1", i, level_o, drop_cnt_o); end
      end
      n_tests++; if (instret_o !== 32'd14) begin n_fail++; $display("FAIL b2b_instret got %0d exp 14", instret_o); end
      clear_i = 1'b1;
      set_rec(32'h2800, 32'h00000013, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
      tick();
      clear_i = 1'b0; ret_valid_i = 1'b0;
      n_tests++; if (level_o !== 4'd0 || tr_valid_o !== 1'b0 || overflow_o !== 1'b0) begin n_fail++; $display("FAIL clr got lvl=%0d valid=%0b ovf=%0b exp 0 0 0", level_o, tr_valid_o, overflow_o); end
      n_tests++; if (instret_o !== 32'd14 || drop_cnt_o !== 32'd1) begin n_fail++; $display("FAIL clr_cnt got instret=%0d drop=%0d exp 14 1", instret_o, drop_cnt_o); end
      tr_ready_i = 1'b0;
      set_rec(32'h3000, 32'h00000013, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
      tick();
      ret_valid_i = 1'b0;
      n_tests++; if (level_o !== 4'd1 || tr_pc_o !== 32'h3000) begin n_fail++; $display("FAIL clr_push got lvl=%0d pc=%h exp 1 3000", level_o, tr_pc_o); end
   endtask

   task automatic test_stall();
      do_reset();
      for (int k = 1; k <= 7; k++) begin
         set_rec(32'(32'h4000 + 4 * k), 32'h00000013, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
         tick();
         n_tests++; if (level_o !== 4'(k) || stall_req_o !== (STALL_EN && k >= 6)) begin n_fail++; $display("FAIL stall_up%0d got lvl=%0d stall=%0b exp %0d %0b", k, level_o, stall_req_o, k, STALL_EN && k >= 6); end
      end
      ret_valid_i = 1'b0; tr_ready_i = 1'b1;
      for (int k = 6; k >= 5; k--) begin
         tick();
         n_tests++; if (level_o !== 4'(k) || stall_req_o !== (STALL_EN && k >= 6)) begin n_fail++; $display("FAIL stall_dn%0d got lvl=%0d stall=%0b exp %0d %0b", k, level_o, stall_req_o, k, STALL_EN && k >= 6); end
      end
   endtask

   initial begin
      test_reset();
      test_bubble();
      test_canon();
      test_overflow();
      test_back_to_back();
      test_stall();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
